// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared glyph constants, mode encodings and run state for the scrolling display
package seg_disp_pkg;
  localparam int GLYPH_W = 5;
  localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 5'd27;
  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_LOOP = 2'b01;
  localparam logic [1:0] MODE_ONCE = 2'b10;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/seg_glyph_rom.sv
// seg_glyph_rom: glyph code to 7-segment pattern, a..g on bit0..bit6, active-high
module seg_glyph_rom
  import seg_disp_pkg::*;
(
  input  logic [GLYPH_W-1:0] code,
  output logic [6:0]         seg
);
  always_comb begin
    seg = 7'b0000000;
    case (code)
      5'd0:  seg = 7'b0111111;
      5'd1:  seg = 7'b0000110;
      5'd2:  seg = 7'b1011011;
      5'd3:  seg = 7'b1001111;
      5'd4:  seg = 7'b1100110;
      5'd5:  seg = 7'b1101101;
      5'd6:  seg = 7'b1111101;
      5'd7:  seg = 7'b0000111;
      5'd8:  seg = 7'b1111111;
      5'd9:  seg = 7'b1101111;
      5'd10: seg = 7'b1110111;
      5'd11: seg = 7'b1111100;
      5'd12: seg = 7'b0111001;
      5'd13: seg = 7'b1011110;
      5'd14: seg = 7'b1111001;
      5'd15: seg = 7'b1110001;
      5'd16: seg = 7'b0111101;
      5'd17: seg = 7'b1110110;
      5'd18: seg = 7'b0011110;
      5'd19: seg = 7'b0111000;
      5'd20: seg = 7'b1010100;
      5'd21: seg = 7'b0111111;
      5'd22: seg = 7'b1110011;
      5'd23: seg = 7'b1010000;
      5'd24: seg = 7'b0111110;
      5'd25: seg = 7'b1101101;
      5'd26: seg = 7'b0011100;
      default: seg = 7'b0000000;
    endcase
  end
endmodule

// File: rtl/seg_scroll_display.sv
// seg_scroll_display: time-multiplexed 7-segment driver showing a scrolling window of a glyph buffer
module seg_scroll_display
  import seg_disp_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int MSG_LEN    = 16,
  parameter int SCAN_DIV   = 50000,
  parameter int SCROLL_DIV = 25000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [GLYPH_W-1:0]         wr_data,
  input  logic [$clog2(MSG_LEN):0]   len,
  input  logic [1:0]                 mode,
  input  logic                       start,
  input  logic                       stop,
  output logic [6:0]                 seg,
  output logic [DIGITS-1:0]          an,
  output logic                       busy,
  output logic                       done
);
  localparam int AW = $clog2(MSG_LEN);
  localparam int PW = $clog2(MSG_LEN + DIGITS) + 1;
  localparam int IW = $clog2(DIGITS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(SCROLL_DIV);
  localparam logic [AW:0] WL = (AW+1)'(MSG_LEN);
  localparam logic [PW-1:0] ML = PW'(MSG_LEN);

  state_t               state;
  logic [GLYPH_W-1:0]   mem [MSG_LEN];
  logic [PW-1:0]        len_q, offset, ptr;
  logic [1:0]           mode_q;
  logic [IW-1:0]        idx;
  logic [SW-1:0]        scan_cnt;
  logic [CW-1:0]        scroll_cnt;
  logic [PW-1:0]        len_c, ptr_inc, ptr_nxt, off_inc;
  logic                 once, scrolling, scan_wrap, scroll_wrap, scroll_tick, idx_last, fin;
  logic [GLYPH_W-1:0]   glyph;
  logic [6:0]           seg_c;

  assign len_c       = (PW'(len) > ML) ? ML : PW'(len);
  assign once        = mode_q == MODE_ONCE;
  assign scrolling   = once || mode_q == MODE_LOOP;
  assign scan_wrap   = scan_cnt == SW'(SCAN_DIV - 1);
  assign scroll_wrap = scroll_cnt == CW'(SCROLL_DIV - 1);
  assign scroll_tick = scrolling && scroll_wrap;
  assign idx_last    = idx == IW'(DIGITS - 1);
  assign ptr_inc     = ptr + PW'(1);
  // Frame restarts at offset; loop/static wrap the pointer so short messages repeat
  assign ptr_nxt     = idx_last ? offset : (!once && ptr_inc >= len_q) ? '0 : ptr_inc;
  assign off_inc     = offset + PW'(1);
  // Once mode finishes on the tick after the all-blank window (offset == len) was shown
  assign fin         = scroll_tick && once && offset == len_q;
  assign glyph       = (ptr >= len_q) ? GLYPH_BLANK : mem[ptr[AW-1:0]];

  seg_glyph_rom u_rom (.code(glyph), .seg(seg_c));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      mode_q     <= MODE_STATIC;
      offset     <= '0;
      ptr        <= '0;
      idx        <= '0;
      scan_cnt   <= '0;
      scroll_cnt <= '0;
      seg        <= '0;
      an         <= '1;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++) mem[i] <= GLYPH_BLANK;
    end else begin
      done <= 1'b0;
      if (wr_en && {1'b0, wr_addr} < WL) mem[wr_addr] <= wr_data;
      if (stop) begin
        state      <= IDLE;
        busy       <= 1'b0;
        scan_cnt   <= '0;
        scroll_cnt <= '0;
        seg        <= '0;
        an         <= '1;
      end else if (start) begin
        state      <= RUN;
        busy       <= 1'b1;
        len_q      <= len_c;
        mode_q     <= mode;
        offset     <= '0;
        ptr        <= '0;
        idx        <= '0;
        scan_cnt   <= '0;
        scroll_cnt <= '0;
        seg        <= '0;
        an         <= '1;
      end else if (state == RUN && fin) begin
        state      <= IDLE;
        busy       <= 1'b0;
        done       <= 1'b1;
        scan_cnt   <= '0;
        scroll_cnt <= '0;
        seg        <= '0;
        an         <= '1;
      end else if (state == RUN) begin
        seg        <= seg_c;
        an         <= ~(DIGITS'(1) << idx);
        scan_cnt   <= scan_wrap ? '0 : scan_cnt + SW'(1);
        scroll_cnt <= scrolling ? (scroll_wrap ? '0 : scroll_cnt + CW'(1)) : '0;
        if (scan_wrap) begin
          idx <= idx_last ? '0 : idx + IW'(1);
          ptr <= ptr_nxt;
        end
        if (scroll_tick) offset <= once ? off_inc : (off_inc >= len_q ? '0 : off_inc);
      end else begin
        scan_cnt   <= '0;
        scroll_cnt <= '0;
        seg        <= '0;
        an         <= '1;
      end
    end
  end
endmodule

// File: tb/tb_seg_scroll_display.sv
// tb_seg_scroll_display: scoreboard bench; expected frames from a message/offset model, checked by a frame monitor
module tb_seg_scroll_display;
  localparam int DIGITS = 4, MSG_LEN = 8, SCAN_DIV = 2, SCROLL_DIV = 16;
  localparam int F = DIGITS * SCAN_DIV;
  localparam logic [6:0] GT [27] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
    7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76, 7'h1E, 7'h38, 7'h54, 7'h3F,
    7'h73, 7'h50, 7'h3E, 7'h6D, 7'h1C};

  logic clk = 0, rst_n = 0, wr_en = 0, start = 0, stop = 0;
  logic [2:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic [3:0] len = '0;
  logic [1:0] mode = '0;
  logic [6:0] seg;
  logic [3:0] an;
  logic busy, done;
  int checks = 0, errors = 0, done_seen = 0;
  logic [27:0] expq [$];
  logic [4:0] tbm [MSG_LEN];

  always #5 clk = ~clk;

  seg_scroll_display #(.DIGITS(DIGITS), .MSG_LEN(MSG_LEN), .SCAN_DIV(SCAN_DIV), .SCROLL_DIV(SCROLL_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .len(len),
    .mode(mode), .start(start), .stop(stop), .seg(seg), .an(an), .busy(busy), .done(done));

  function automatic logic [6:0] glyph(input int c);
    return (c < 27) ? GT[c] : 7'h00;
  endfunction

  function automatic int clampl(input int l);
    return (l > MSG_LEN) ? MSG_LEN : l;
  endfunction

  // Window shown for a given offset: glyphs offset..offset+DIGITS-1, wrapped or blank past the end
  function automatic logic [27:0] window(input int m, input int l, input int o);
    logic [27:0] w = '0;
    for (int d = 0; d < DIGITS; d++) begin
      int p = o + d, c = 27;
      if (l > 0) c = (m == 2) ? ((p < l) ? int'(tbm[p]) : 27) : int'(tbm[p % l]);
      w[d*7 +: 7] = glyph(c);
    end
    return w;
  endfunction

  // Frame k latches the offset reached by scroll ticks that happened before its first digit
  function automatic int offset_at(input int m, input int l, input int k);
    int t = (k == 0) ? 0 : (k * F - 1) / SCROLL_DIV;
    if (m == 1) return (l > 0) ? t % l : 0;
    if (m == 2) return t;
    return 0;
  endfunction

  function automatic int frames_before(input int end_cycle);
    int n = 0;
    while (n * F + (DIGITS - 1) * SCAN_DIV + 1 < end_cycle) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    static int fpos = -1, lastd = -1;
    static logic [27:0] fw = '0;
    int d;
    logic [27:0] want;
    if (done) done_seen++;
    if (an == 4'hF) begin
      fpos = -1;
      lastd = -1;
    end else if ($countones(~an) != 1) begin
      checks++;
      errors++;
      $display("FAIL an_onehot got %b required one active-low digit", an);
      fpos = -1;
    end else begin
      d = 0;
      for (int i = 0; i < DIGITS; i++) if (!an[i]) d = i;
      if (d != lastd) begin
        lastd = d;
        if (d == 0) begin
          fw = '0;
          fw[6:0] = seg;
          fpos = 0;
        end else if (fpos == d - 1) begin
          fw[d*7 +: 7] = seg;
          fpos = d;
          if (d == DIGITS - 1) begin
            fpos = -1;
            if (expq.size() > 0) begin
              want = expq.pop_front();
              checks++;
              if (fw !== want) begin
                errors++;
                $display("FAIL frame got %h required %h", fw, want);
              end
            end
          end
        end else if (fpos >= 0) begin
          checks++;
          errors++;
          $display("FAIL digit_order got digit %0d after %0d", d, fpos);
          fpos = -1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, want);
    end
  endtask

  task automatic wr(input int a, input int v);
    @(negedge clk);
    wr_en = 1;
    wr_addr = 3'(a);
    wr_data = 5'(v);
    tbm[a] = 5'(v);
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic pulse_start(input int m, input int l);
    @(negedge clk);
    mode = 2'(m);
    len = 4'(l);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic push_frames(input int m, input int l, input int n);
    for (int k = 0; k < n; k++) expq.push_back(window(m, l, offset_at(m, l, k)));
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (expq.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, expq.size(), 0);
  endtask

  task automatic run_free(input int m, input int l, input int n);
    pulse_start(m, l);
    push_frames(m, clampl(l), n);
    drain("frames_drain");
    @(negedge clk);
    stop = 1;
    @(negedge clk);
    stop = 0;
    check("stop_busy", busy, 0);
    check("stop_an", an, 4'hF);
  endtask

  task automatic run_once(input int l);
    int lc = clampl(l), dc = SCROLL_DIV * (clampl(l) + 1), c = 0;
    pulse_start(2, l);
    push_frames(2, lc, frames_before(dc));
    while (!done && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("done_cycle", c, dc);
    check("done_busy", busy, 0);
    check("done_an", an, 4'hF);
    check("done_seg", seg, 0);
    @(negedge clk);
    check("done_width", done, 0);
    check("once_frames", expq.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int s, dc;
    for (int i = 0; i < MSG_LEN; i++) tbm[i] = 5'd27;
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1;
    run_free(0, 4, 3);

    wr(0, 17); wr(1, 14); wr(2, 19); wr(3, 21);
    pulse_start(0, 4);
    push_frames(0, 4, 28);
    drain("static_drain");
    wr(2, 8);
    push_frames(0, 4, 3);
    drain("write_run_drain");
    @(negedge clk); stop = 1; @(negedge clk); stop = 0;

    for (int i = 0; i < 5; i++) wr(i, i + 1);
    run_free(1, 5, 12);
    wr(0, 7); wr(1, 8);
    run_free(1, 2, 6);

    for (int i = 0; i < 4; i++) wr(i, i);
    run_once(4);
    run_once(0);

    pulse_start(1, 5);
    repeat (5) @(negedge clk);
    start = 1; stop = 1;
    @(negedge clk);
    start = 0; stop = 0;
    check("startstop_busy", busy, 0);
    check("startstop_an", an, 4'hF);
    repeat (10) @(negedge clk);
    check("startstop_idle", an, 4'hF);

    for (int i = 0; i < MSG_LEN; i++) wr(i, 7 - i);
    run_free(1, 12, 20);

    for (int it = 0; it < 8; it++) begin
      int m, l;
      for (int a = 0; a < MSG_LEN; a++) wr(a, $urandom_range(0, 31));
      m = $urandom_range(0, 3);
      l = $urandom_range(0, 12);
      if (m == 2) run_once(l);
      else run_free(m, l, $urandom_range(4, 20));
    end

    for (int i = 0; i < 4; i++) wr(i, i);
    dc = SCROLL_DIV * 5;
    pulse_start(2, 4);
    push_frames(2, 4, frames_before(dc - 1));
    repeat (dc - 2) @(negedge clk);
    s = done_seen;
    rst_n = 0;
    @(negedge clk);
    check("midrst_an", an, 4'hF);
    check("midrst_seg", seg, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_frames", expq.size(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < MSG_LEN; i++) tbm[i] = 5'd27;
    repeat (20) @(negedge clk);
    check("midrst_no_done", done_seen, s);
    run_free(0, 4, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
